// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants, state encoding and a nibble-range helper for the BCD subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_W     = 4;
  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when a nibble is not a legal decimal digit.
  function automatic logic nibble_bad(input logic [BCD_W-1:0] n);
    return n > BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Operand/result bundle for the serial BCD subtractor.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while busy is low.
// Signals: start, a, b (requester -> subtractor); diff, neg, err, busy, done (subtractor -> requester).
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic [4*DIGITS-1:0] diff;
  logic                neg;
  logic                err;
  logic                busy;
  logic                done;

  modport master (output start, a, b, input diff, neg, err, busy, done);
  modport slave  (input start, a, b, output diff, neg, err, busy, done);
endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// Single-digit BCD subtract with borrow: d = a - b - bin, wrapped into 0..9.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b (digits), bin (borrow in); d (result digit), bout (borrow out).
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t;

  // Five bits cover -16..15, so bit 4 is exactly the "went negative" flag.
  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    bout = t[4];
    d    = bout ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD A - B, LSD first, ripple borrow; ten's-complement negative
//   results, or magnitude + neg when BCD_SUB_MAGNITUDE_EN is defined (extra FIX pass).
// Latency: done in the state following DIGITS RUN cycles (+DIGITS FIX cycles when negative with the macro).
// Backpressure: start ignored while busy (RUN/FIX/DONE); results held until next accepted start.
// Ports: clk, rst (async, active-high); bus.slave: start/a/b in, diff/neg/err/busy/done out.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int W  = BCD_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, diff_q;
  logic [IW-1:0] idx;
  logic          borrow, neg_q, err_q;
  logic [3:0]    op_a, op_b, d;
  logic          bout;
  logic          in_bad;

  // Range check on the operands at the moment they are captured.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      in_bad = in_bad | nibble_bad(bus.a[i*BCD_W +: BCD_W]) | nibble_bad(bus.b[i*BCD_W +: BCD_W]);
    end
  end

  // One digit subtractor; FIX reuses it as 0 - diff to turn ten's complement into magnitude.
  always_comb begin
    op_a = a_q[idx*BCD_W +: BCD_W];
    op_b = b_q[idx*BCD_W +: BCD_W];
`ifdef BCD_SUB_MAGNITUDE_EN
    if (state == ST_FIX) begin
      op_a = '0;
      op_b = diff_q[idx*BCD_W +: BCD_W];
    end
`endif
  end

  bcd_digit_sub u_digit (
    .a    (op_a),
    .b    (op_b),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (idx == LAST) begin
`ifdef BCD_SUB_MAGNITUDE_EN
          state_nxt = (bout && !err_q) ? ST_FIX : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      ST_FIX:  if (idx == LAST) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= in_bad;
          end
        end
        ST_RUN: begin
          diff_q[idx*BCD_W +: BCD_W] <= d;
          borrow <= bout;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            // Restart index/borrow so a following FIX pass begins at digit 0.
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= bout & ~err_q;
            if (err_q) diff_q <= '0;
          end
        end
`ifdef BCD_SUB_MAGNITUDE_EN
        ST_FIX: begin
          diff_q[idx*BCD_W +: BCD_W] <= d;
          borrow <= bout;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            idx    <= '0;
            borrow <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;
  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (DIGITS=4): directed vectors pushed as
// expectations at start, checked by an independent monitor on each done pulse.
// Honours BCD_SUB_MAGNITUDE_EN for the negative-result expectations.
module tb_bcd_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] diff;
    logic        neg;
    logic        err;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  int   done_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("op%0d_diff", e.id), 32'(bus.diff), 32'(e.diff));
        check($sformatf("op%0d_neg", e.id), 32'(bus.neg), 32'(e.neg));
        check($sformatf("op%0d_err", e.id), 32'(bus.err), 32'(e.err));
        check($sformatf("op%0d_lat", e.id), 32'(cyc - e.start_cyc + 1), 32'(e.lat));
      end
    end
  end

  // Issue start at a negedge; the next posedge (cycle cyc+1) samples it.
  task automatic issue(input int id, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ed, input logic en, input logic ee, input int lat);
    exp_t e;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    e.id = id; e.diff = ed; e.neg = en; e.err = ee; e.lat = lat; e.start_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("op%0d_done_seen", id), 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input int id, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic en, input logic ee, input int lat);
    @(negedge clk);
    issue(id, av, bv, ed, en, ee, lat);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;  // later operand changes must not matter
    bus.b     = ~bv;
    check($sformatf("op%0d_busy", id), 32'(bus.busy), 32'd1);
    wait_done(id);
    @(negedge clk);
    check($sformatf("op%0d_idle", id), 32'(bus.busy), 32'd0);
    check($sformatf("op%0d_hold", id), 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    int snap;
    logic [15:0] neg_diff;
    int          neg_lat;
`ifdef BCD_SUB_MAGNITUDE_EN
    neg_diff = 16'h0001; neg_lat = 9;
`else
    neg_diff = 16'h9999; neg_lat = 5;
`endif
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_neg",  32'(bus.neg),  32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    run_op(1, 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5);
    run_op(2, 16'h0001, 16'h0002, neg_diff, 1'b1, 1'b0, neg_lat);
    run_op(3, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 5);
    check("err_held", 32'(bus.err), 32'd1);
    run_op(4, 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5);
    run_op(5, 16'h4321, 16'h4321, 16'h0000, 1'b0, 1'b0, 5);

    // start pulses during RUN and during DONE must be ignored.
    snap = done_cnt;
    @(negedge clk);
    issue(6, 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'h9999; bus.b = 16'h0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6);
    bus.a = 16'h0001; bus.b = 16'h0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_done_cnt", 32'(done_cnt - snap), 32'd1);
    check("ignored_start_busy", 32'(bus.busy), 32'd0);
    check("ignored_start_diff", 32'(bus.diff), 32'h4198);

    // Reset in the middle of an erroneous run: no done, everything cleared.
    snap = done_cnt;
    @(negedge clk);
    bus.a = 16'h12A4; bus.b = 16'h0001; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_err", 32'(bus.err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_err",  32'(bus.err),  32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - snap), 32'd0);

    run_op(7, 16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
